leitor_tabuleiro: RTL and testbench

Scans the 8x8 reed-switch matrix under the board and reports each newly placed piece as a 4-bit row/column pair with a held `temJogada` flag. It sits directly upstream of the game datapath, whose move registers and edge detector consume its outputs. It also filters contact bounce: a board change counts only after several consecutive identical full scans. Piece removals update the internal board image silently.

---
 rtl/leitor_tabuleiro.sv | 146 ++++++++++++++
 tb/tb_leitor_tabuleiro.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_tabuleiro.sv
// Reed-switch board scanner: drives one row at a time, debounces full 8x8 scans
// and reports each newly placed piece as a held row/column pair.
module leitor_tabuleiro #(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] colunas,
    input  logic       limpa,
    output logic [7:0] linhaSel,
    output logic [3:0] jogadaLinha,
    output logic [3:0] jogadaColuna,
    output logic       temJogada,
    output logic       pronto
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {
        ESPERA,
        AMOSTRA,
        COMPARA
    } estado_t;

    estado_t        estado_q;
    logic [2:0]     r_q;
    logic [SW-1:0]  settle_q;
    logic [CW-1:0]  cont_q;
    logic [63:0]    varredura_q;
    logic [63:0]    anterior_q;
    logic [63:0]    estavel_q;
    logic [7:0]     linha_sel_q;
    logic [2:0]     jog_linha_q;
    logic [2:0]     jog_coluna_q;
    logic           tem_jogada_q;
    logic           pronto_q;

    logic [CW-1:0]  cont_d;
    logic [63:0]    novos_d;
    logic [5:0]     k_d;
    logic           livre_d;

    always_comb begin
        if (varredura_q == anterior_q) begin
            if (cont_q == CW'(DEBOUNCE)) begin
                cont_d = cont_q;
            end else begin
                cont_d = cont_q + 1'b1;
            end
        end else begin
            cont_d = CW'(1);
        end

        novos_d = varredura_q & ~estavel_q;

        // Descending walk so the lowest set square wins.
        k_d = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (novos_d[i]) begin
                k_d = 6'(i);
            end
        end

        livre_d = !tem_jogada_q || limpa;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= ESPERA;
            r_q          <= 3'd0;
            settle_q     <= '0;
            cont_q       <= '0;
            varredura_q  <= 64'd0;
            anterior_q   <= 64'd0;
            estavel_q    <= 64'd0;
            linha_sel_q  <= 8'h01;
            jog_linha_q  <= 3'd0;
            jog_coluna_q <= 3'd0;
            tem_jogada_q <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            // An acknowledge clears on any edge; a report issued below overrides it.
            if (limpa) begin
                tem_jogada_q <= 1'b0;
            end

            case (estado_q)
                ESPERA: begin
                    if (settle_q == SW'(SETTLE - 1)) begin
                        settle_q <= '0;
                        estado_q <= AMOSTRA;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end

                AMOSTRA: begin
                    varredura_q[{r_q, 3'b000} +: 8] <= colunas;
                    linha_sel_q <= {linha_sel_q[6:0], linha_sel_q[7]};
                    if (r_q == 3'd7) begin
                        r_q      <= 3'd0;
                        estado_q <= COMPARA;
                    end else begin
                        r_q      <= r_q + 3'd1;
                        estado_q <= ESPERA;
                    end
                end

                COMPARA: begin
                    cont_q     <= cont_d;
                    anterior_q <= varredura_q;
                    estado_q   <= ESPERA;
                    if (cont_d == CW'(DEBOUNCE)) begin
                        if (!pronto_q) begin
                            // First stable image is the baseline; nothing on it is reported.
                            estavel_q <= varredura_q;
                            pronto_q  <= 1'b1;
                        end else if (livre_d) begin
                            if (novos_d != 64'd0) begin
                                jog_linha_q  <= k_d[5:3];
                                jog_coluna_q <= k_d[2:0];
                                tem_jogada_q <= 1'b1;
                                estavel_q    <= (estavel_q & varredura_q) | (64'd1 << k_d);
                            end else begin
                                estavel_q <= estavel_q & varredura_q;
                            end
                        end
                    end
                end

                default: begin
                    estado_q <= ESPERA;
                end
            endcase
        end
    end

    assign linhaSel     = linha_sel_q;
    assign jogadaLinha  = {1'b0, jog_linha_q};
    assign jogadaColuna = {1'b0, jog_coluna_q};
    assign temJogada    = tem_jogada_q;
    assign pronto       = pronto_q;

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Bench for leitor_tabuleiro: emulates the switch matrix, runs scripted and random
// board sequences scan by scan, and compares outputs against a scan-level model.
module tb_leitor_tabuleiro;

    localparam int S  = 4;
    localparam int D  = 3;
    localparam int RP = S + 1;
    localparam int P  = 8 * RP + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       limpa = 1'b0;
    logic [7:0] colunas;
    logic [7:0] linhaSel;
    logic [3:0] jogadaLinha;
    logic [3:0] jogadaColuna;
    logic       temJogada;
    logic       pronto;

    logic [63:0] tab = 64'd0;

    always #5 clock = ~clock;

    // The board: the selected row's switches appear on the column lines.
    always_comb begin
        colunas = 8'h00;
        for (int r = 0; r < 8; r++) begin
            if (linhaSel[r]) colunas = colunas | tab[r*8 +: 8];
        end
    end

    leitor_tabuleiro #(.SETTLE(S), .DEBOUNCE(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .colunas     (colunas),
        .limpa       (limpa),
        .linhaSel    (linhaSel),
        .jogadaLinha (jogadaLinha),
        .jogadaColuna(jogadaColuna),
        .temJogada   (temJogada),
        .pronto      (pronto)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_scan   = 0;

    logic [63:0] hist[$];
    logic [63:0] estavel_m;
    logic        pronto_m;
    logic        tem_m;
    logic [3:0]  lin_m;
    logic [3:0]  col_m;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic modelo_reset();
        hist.delete();
        estavel_m = 64'd0;
        pronto_m  = 1'b0;
        tem_m     = 1'b0;
        lin_m     = 4'd0;
        col_m     = 4'd0;
    endtask

    // End of a full scan: a scan counts once the last D scans are identical.
    task automatic modelo_compara(input logic [63:0] img, input logic lim);
        int  iguais;
        logic livre;
        logic achou;
        logic [63:0] novos;
        hist.push_back(img);
        if (hist.size() > D) void'(hist.pop_front());
        iguais = 1;
        achou  = 1'b0;
        for (int i = hist.size() - 1; i > 0; i--) begin
            if (!achou && hist[i] == hist[i-1]) iguais++;
            else achou = 1'b1;
        end
        livre = !tem_m || lim;
        if (lim) tem_m = 1'b0;
        if (iguais == D) begin
            if (!pronto_m) begin
                estavel_m = img;
                pronto_m  = 1'b1;
            end else if (livre) begin
                novos = img & ~estavel_m;
                achou = 1'b0;
                for (int k = 0; k < 64; k++) begin
                    if (!achou && novos[k]) begin
                        achou     = 1'b1;
                        lin_m     = 4'(k / 8);
                        col_m     = 4'(k % 8);
                        tem_m     = 1'b1;
                        estavel_m = (estavel_m & img) | (64'd1 << k);
                    end
                end
                if (!achou) estavel_m = estavel_m & img;
            end
        end
    endtask

    // One full scan with the board held at img; limpa pulses for one cycle at limpa_at.
    task automatic varre(input logic [63:0] img, input int limpa_at);
        tab = img;
        for (int off = 0; off < P; off++) begin
            if (off == P - 1) begin
                verifica("linhaSel_compara", linhaSel, 8'h01);
                verifica("pronto_pre", pronto, pronto_m);
            end else if (off % RP == 0) begin
                verifica("linhaSel", linhaSel, 8'h01 << (off / RP));
            end
            limpa = (off == limpa_at);
            ciclo();
            if (off == P - 1) begin
                modelo_compara(img, limpa);
            end else if (limpa) begin
                tem_m = 1'b0;
                verifica("limpa_clear", temJogada, 1'b0);
            end
        end
        limpa = 1'b0;
        verifica("temJogada", temJogada, tem_m);
        verifica("pronto", pronto, pronto_m);
        verifica("jogadaLinha", jogadaLinha, lin_m);
        verifica("jogadaColuna", jogadaColuna, col_m);
        $display("scan %0d img=%016h limpa_at=%0d tem=%0b pos=(%0d,%0d) pronto=%0b",
                 n_scan, img, limpa_at, temJogada, jogadaLinha, jogadaColuna, pronto);
        n_scan++;
    endtask

    // Reset asserted between edges: outputs must drop before any clock edge.
    task automatic reinicia();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        verifica("rst_linhaSel", linhaSel, 8'h01);
        verifica("rst_temJogada", temJogada, 1'b0);
        verifica("rst_pronto", pronto, 1'b0);
        verifica("rst_jogadaLinha", jogadaLinha, 4'd0);
        verifica("rst_jogadaColuna", jogadaColuna, 4'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        modelo_reset();
    endtask

    initial begin
        logic [63:0] b0, b1, b2, b3, b4, img;
        int hold;
        modelo_reset();
        repeat (2) @(posedge clock);
        #1;
        verifica("init_linhaSel", linhaSel, 8'h01);
        verifica("init_temJogada", temJogada, 1'b0);
        verifica("init_pronto", pronto, 1'b0);
        reset = 1'b0;

        // Empty board: baseline captured after three identical scans.
        repeat (4) varre(64'd0, -1);

        // Corner pieces present from reset are never reported.
        reinicia();
        b0 = 64'd1 | (64'd1 << 63);
        repeat (4) varre(b0, -1);

        // Place (3,5), hold well past 200 cycles, then acknowledge.
        b1 = b0 | (64'd1 << 29);
        repeat (8) varre(b1, -1);
        varre(b1, 10);

        // Bouncing (2,2) for five scans, then held.
        for (int i = 0; i < 5; i++) varre((i % 2 == 0) ? (b1 | (64'd1 << 18)) : b1, -1);
        b2 = b1 | (64'd1 << 18);
        repeat (3) varre(b2, -1);
        varre(b2, 5);

        // (6,0) and (1,4) together: lowest index first, second after acknowledge.
        b3 = b2 | (64'd1 << 48) | (64'd1 << 12);
        repeat (3) varre(b3, -1);
        varre(b3, 7);
        varre(b3, 3);

        // Acknowledge landing on the reporting cycle keeps the flag high.
        b4 = b3 | (64'd1 << 33) | (64'd1 << 46);
        repeat (3) varre(b4, -1);
        varre(b4, P - 1);
        varre(b4, 0);

        // Removal is silent; re-placing is reported.
        repeat (4) varre(b4 & ~64'd1, -1);
        repeat (3) varre(b4, -1);

        // Reset while a report is pending.
        reinicia();

        // Random placements, removals, glitches and acknowledges.
        img = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
        for (int seg = 0; seg < 22; seg++) begin
            if ($urandom_range(0, 3) == 0) begin
                varre(img ^ (64'd1 << $urandom_range(0, 63)), -1);
            end
            for (int f = 0; f < 2; f++) begin
                hold = $urandom_range(0, 63);
                if (f == 0 || $urandom_range(0, 1) == 1) img[hold] = ~img[hold];
            end
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                varre(img, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, P - 1)) : -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
